// File: rtl/lsu_ctrl_pkg.sv
// Shared types and constants for the load/store unit controller:
// funct3 codes, FSM states, access size masks and the default ack timeout.
package lsu_pkg;

    localparam int DEFAULT_ACK_TIMEOUT = 255;

    // RV32I load/store width codes.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Byte-enable patterns for an aligned access of each size.
    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    // Size mask for an operation; MASK_NONE marks an illegal funct3.
    function automatic logic [3:0] size_mask(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B:    return MASK_B;
            F3_H:    return MASK_H;
            F3_W:    return MASK_W;
            F3_BU:   return store ? MASK_NONE : MASK_B;
            F3_HU:   return store ? MASK_NONE : MASK_H;
            default: return MASK_NONE;
        endcase
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] offset);
        return ((mask == MASK_H) && offset[0]) || ((mask == MASK_W) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load data extraction: selects the addressed bytes out of the (up to two)
// memory words, then sign- or zero-extends according to funct3.
// Only the low 24 bits of the second word can ever land in the result,
// so the input window is 56 bits wide.
module load_align
    import lsu_pkg::*;
(
    input  logic [55:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0] lane [7];
    logic [7:0] win  [4];

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
        // win[n] is the n-th byte at or after the request address.
        for (gi = 0; gi < 4; gi++) begin : g_win
            assign win[gi] = lane[3'(gi) + {1'b0, offset}];
        end
    endgenerate

    // Truncate to the access size and extend to 32 bits.
    always_comb begin
        data = 32'h0;
        case (funct3)
            F3_B:    data = {{24{win[0][7]}}, win[0]};
            F3_H:    data = {{16{win[1][7]}}, win[1], win[0]};
            F3_W:    data = {win[3], win[2], win[1], win[0]};
            F3_BU:   data = {24'h0, win[0]};
            F3_HU:   data = {16'h0, win[1], win[0]};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core request at a time, performs
// one or two word accesses on the data-memory port, and returns a single
// response with load data or an error flag.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN -- when defined, misaligned
// halfword/word accesses are executed (split across two words if needed);
// when undefined they are answered with an error and never reach memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e            state_reg, state_next;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic [2:0]        funct3_reg;
    logic              store_reg;
    logic [31:0]       rdata0_reg;
    logic [31:0]       rsp_data_reg;
    logic              rsp_err_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;

    // Request classification, evaluated on the live request fields.
    logic [3:0] req_mask;
    logic       reject;
    assign req_mask = size_mask(req_store, req_funct3);
`ifdef LSU_MISALIGN_SPLIT_EN
    assign reject = (req_mask == MASK_NONE);
`else
    assign reject = (req_mask == MASK_NONE) || is_misaligned(req_mask, req_addr[1:0]);
`endif

    // Access geometry, derived from the latched request.
    logic [3:0] cur_mask;
    logic [7:0] lane_mask;
    logic       spans;
    logic [4:0] shift_lo;
    logic [5:0] shift_hi;
    logic       in_access;
    logic       timeout;
    assign cur_mask  = size_mask(store_reg, funct3_reg);
    assign lane_mask = {4'b0000, cur_mask} << addr_reg[1:0];
    assign spans     = |lane_mask[7:4];
    assign shift_lo  = {addr_reg[1:0], 3'b000};
    assign shift_hi  = 6'd32 - {1'b0, shift_lo};
    assign in_access = (state_reg == S_ACC0) || (state_reg == S_ACC1);
    assign timeout   = (wait_cnt_reg == CNT_LAST);

    // In ACC1 the first word comes from the capture register and the second
    // from the bus; otherwise the bus word is the only one.
    logic [31:0] rdata_lo;
    logic [23:0] rdata_hi;
    logic [31:0] load_data;
    assign rdata_lo = (state_reg == S_ACC1) ? rdata0_reg : mem_rdata;
    assign rdata_hi = (state_reg == S_ACC1) ? mem_rdata[23:0] : 24'h0;

    load_align u_load_align (
        .rdata  ({rdata_hi, rdata_lo}),
        .offset (addr_reg[1:0]),
        .funct3 (funct3_reg),
        .data   (load_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an ack always wins over a coincident timeout.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (req_valid) state_next = reject ? S_RESP : S_ACC0;
            S_ACC0: begin
                if (mem_ack)      state_next = spans ? S_ACC1 : S_RESP;
                else if (timeout) state_next = S_RESP;
            end
            S_ACC1: if (mem_ack || timeout) state_next = S_RESP;
            S_RESP: if (rsp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode; memory fields depend only on state and latched request,
    // so they stay put for as long as an access waits for its ack.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        case (state_reg)
            S_IDLE: req_ready = 1'b1;
            S_ACC0: begin
                mem_req   = 1'b1;
                mem_we    = store_reg;
                mem_addr  = {addr_reg[31:2], 2'b00};
                mem_be    = lane_mask[3:0];
                mem_wdata = wdata_reg << shift_lo;
            end
            S_ACC1: begin
                mem_req   = 1'b1;
                mem_we    = store_reg;
                mem_addr  = {addr_reg[31:2] + 30'd1, 2'b00};
                mem_be    = lane_mask[7:4];
                mem_wdata = wdata_reg >> shift_hi;
            end
            S_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Wait counter: cleared on entering an access state, counts ackless cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_reg <= '0;
        end else if ((state_next != state_reg) &&
                     ((state_next == S_ACC0) || (state_next == S_ACC1))) begin
            wait_cnt_reg <= '0;
        end else if (in_access && !mem_ack) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    // Request latch, first-word capture and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg     <= 32'h0;
            wdata_reg    <= 32'h0;
            funct3_reg   <= 3'b000;
            store_reg    <= 1'b0;
            rdata0_reg   <= 32'h0;
            rsp_data_reg <= 32'h0;
            rsp_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_reg     <= req_addr;
                        wdata_reg    <= req_wdata;
                        funct3_reg   <= req_funct3;
                        store_reg    <= req_store;
                        rsp_data_reg <= 32'h0;
                        rsp_err_reg  <= reject;
                    end
                end
                S_ACC0: begin
                    if (mem_ack) begin
                        rdata0_reg <= mem_rdata;
                        if (!spans) rsp_data_reg <= store_reg ? 32'h0 : load_data;
                    end else if (timeout) begin
                        rsp_err_reg <= 1'b1;
                    end
                end
                S_ACC1: begin
                    if (mem_ack)      rsp_data_reg <= store_reg ? 32'h0 : load_data;
                    else if (timeout) rsp_err_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a byte-addressed memory model answers the
// memory port with programmable latency, and expectations are built from
// byte-level address arithmetic. Directed cases pin the model with literal
// values; a randomized loop then covers widths, offsets, latencies, timeouts,
// back-pressure and ignored handshakes.
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    lsu_ctrl #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  mem [256];

    // What the last transaction showed on the pins, for literal pinning.
    logic [31:0] obs_rsp_data;
    logic        obs_rsp_err;
    int          obs_first_valid;
    int          obs_req_cycles;
    logic [31:0] obs_addr [2];
    logic [3:0]  obs_be   [2];
    logic [31:0] obs_wd   [2];
    logic        obs_we   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem[{a[7:2], 2'b11}], mem[{a[7:2], 2'b10}], mem[{a[7:2], 2'b01}], mem[{a[7:2], 2'b00}]};
    endfunction

    function automatic void set_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 8'(i)] = w[8*i +: 8];
    endfunction

    // Access size in bytes; 0 for an illegal operation.
    function automatic int f3_size(input logic st, input logic [2:0] f3);
        case (f3)
            3'b000:  return 1;
            3'b001:  return 2;
            3'b010:  return 4;
            3'b100:  return st ? 0 : 1;
            3'b101:  return st ? 0 : 2;
            default: return 0;
        endcase
    endfunction

    task automatic drive_noise();
        req_valid  = 1'($urandom);
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic observe(input int cyc);
        if (mem_req) obs_req_cycles++;
        if (rsp_valid && obs_first_valid < 0) obs_first_valid = cyc;
    endtask

    // One full request/response exchange, starting and ending at a negedge in
    // IDLE. w0/w1: ackless cycles before the ack of each access (-1 = never).
    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int w0, input int w1, input int hold);
        int          size, n_acc, k, j, w, cyc;
        logic        rej, acked, e_err;
        logic [31:0] b, val, e_data;
        logic [31:0] e_addr [2];
        logic [3:0]  e_be   [2];
        logic [31:0] e_wd   [2];

        size = f3_size(st, f3);
        rej  = (size == 0);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (size != 0 && (addr & 32'(size - 1)) != 0) rej = 1'b1;
`endif
        n_acc     = 0;
        e_addr[0] = addr & ~32'd3;
        e_addr[1] = e_addr[0] + 32'd4;
        e_be[0]   = 4'h0;
        e_be[1]   = 4'h0;
        val       = 32'h0;
        for (int kk = 0; kk < 2; kk++) begin
            for (int l = 0; l < 4; l++) begin
                j = 4 * kk + l - int'(addr[1:0]);
                e_wd[kk][8*l +: 8] = (j >= 0 && j < 4) ? wd[8*j +: 8] : 8'h00;
            end
        end
        if (!rej) begin
            n_acc = 1;
            for (int i = 0; i < size; i++) begin
                b = addr + 32'(i);
                k = (b[31:2] == addr[31:2]) ? 0 : 1;
                e_be[k][b[1:0]] = 1'b1;
                if (k == 1) n_acc = 2;
                val[8*i +: 8] = mem[b[7:0]];
            end
        end
        case (f3)
            3'b000:  e_data = {{24{val[7]}}, val[7:0]};
            3'b001:  e_data = {{16{val[15]}}, val[15:0]};
            default: e_data = val;
        endcase
        e_err = rej || (n_acc >= 1 && w0 < 0) || (n_acc == 2 && w1 < 0);
        if (e_err || st) e_data = 32'h0;

        obs_first_valid = -1;
        obs_req_cycles  = 0;
        obs_we[0] = 1'b0; obs_we[1] = 1'b0;
        obs_be[0] = 4'h0; obs_be[1] = 4'h0;
        obs_addr[0] = 32'h0; obs_addr[1] = 32'h0;
        obs_wd[0] = 32'h0; obs_wd[1] = 32'h0;

        chk("req_ready_idle", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        mem_ack    = 1'($urandom);
        mem_rdata  = $urandom;
        rsp_ready  = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        cyc = 1;

        for (int a = 0; a < n_acc; a++) begin
            w     = (a == 0) ? w0 : w1;
            acked = 1'b0;
            for (int c = 0; c < TO && !acked; c++) begin
                observe(cyc);
                chk($sformatf("mem_req[%0d]", a),   mem_req,   1'b1);
                chk($sformatf("mem_addr[%0d]", a),  mem_addr,  e_addr[a]);
                chk($sformatf("mem_be[%0d]", a),    mem_be,    e_be[a]);
                chk($sformatf("mem_we[%0d]", a),    mem_we,    st);
                chk($sformatf("mem_wdata[%0d]", a), mem_wdata, e_wd[a]);
                chk("rsp_valid_busy", rsp_valid, 1'b0);
                chk("req_ready_busy", req_ready, 1'b0);
                if (c == 0) begin
                    obs_addr[a] = mem_addr; obs_be[a] = mem_be;
                    obs_wd[a]   = mem_wdata; obs_we[a] = mem_we;
                end
                drive_noise();
                if (c == w) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(e_addr[a]);
                    acked     = 1'b1;
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
                @(posedge clk);
                if (acked && st) begin
                    for (int l = 0; l < 4; l++)
                        if (e_be[a][l]) mem[{e_addr[a][7:2], 2'(l)}] = e_wd[a][8*l +: 8];
                end
                @(negedge clk);
                mem_ack = 1'b0;
                cyc++;
            end
            if (!acked) break;
        end

        for (int h = 0; h <= hold; h++) begin
            observe(cyc);
            chk("rsp_valid", rsp_valid, 1'b1);
            chk("rsp_data",  rsp_data,  e_data);
            chk("rsp_err",   rsp_err,   e_err);
            chk("mem_req_resp", mem_req, 1'b0);
            chk("req_ready_resp", req_ready, 1'b0);
            if (h == 0) begin
                obs_rsp_data = rsp_data;
                obs_rsp_err  = rsp_err;
            end
            drive_noise();
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            rsp_ready = (h == hold);
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        rsp_ready = 1'b0;
        chk("rsp_valid_done", rsp_valid, 1'b0);
        chk("req_ready_done", req_ready, 1'b1);
        chk("mem_req_done",   mem_req,   1'b0);
        $display("txn store=%0d f3=%03b addr=%08h wdata=%08h -> rsp_data=%08h rsp_err=%0d mem_req_cycles=%0d",
                 st, f3, addr, wd, obs_rsp_data, obs_rsp_err, obs_req_cycles);
    endtask

    initial begin
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          w0, w1;

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_err",   rsp_err,   1'b0);
        chk("reset_rsp_data",  rsp_data,  32'h0);
        chk("reset_mem_req",   mem_req,   1'b0);
        chk("reset_mem_we",    mem_we,    1'b0);
        chk("reset_mem_be",    mem_be,    4'h0);
        chk("reset_mem_addr",  mem_addr,  32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        reset = 1'b0;

        // Word load, zero-wait memory.
        set_word(8'h08, 32'hA5A5A5A5);
        do_txn(1'b0, 3'b010, 32'h08, $urandom, 0, 0, 0);
        chk("lw_be",      obs_be[0],    4'b1111);
        chk("lw_data",    obs_rsp_data, 32'hA5A5A5A5);
        chk("lw_latency", 32'(obs_first_valid), 32'd2);

        // Sub-word loads.
        set_word(8'h08, 32'h80011234);
        do_txn(1'b0, 3'b001, 32'h0A, $urandom, 0, 0, 0);
        chk("lh_be",   obs_be[0],    4'b1100);
        chk("lh_data", obs_rsp_data, 32'hFFFF8001);
        do_txn(1'b0, 3'b100, 32'h0B, $urandom, 1, 0, 1);
        chk("lbu_data", obs_rsp_data, 32'h00000080);

        // Byte store.
        do_txn(1'b1, 3'b000, 32'h05, 32'h000000EE, 0, 0, 0);
        chk("sb_addr",  obs_addr[0],  32'h04);
        chk("sb_be",    obs_be[0],    4'b0010);
        chk("sb_wdata", obs_wd[0],    32'h0000EE00);
        chk("sb_we",    obs_we[0],    1'b1);
        chk("sb_data",  obs_rsp_data, 32'h0);

        // Word load straddling a word boundary.
        set_word(8'h0C, 32'hBBAA0000);
        set_word(8'h10, 32'h0000DDCC);
        do_txn(1'b0, 3'b010, 32'h0E, $urandom, 0, 1, 0);
`ifdef LSU_MISALIGN_SPLIT_EN
        chk("split_be0",  obs_be[0],    4'b1100);
        chk("split_addr1", obs_addr[1], 32'h10);
        chk("split_be1",  obs_be[1],    4'b0011);
        chk("split_data", obs_rsp_data, 32'hDDCCBBAA);
        chk("split_err",  obs_rsp_err,  1'b0);
`else
        chk("misalign_err",     obs_rsp_err, 1'b1);
        chk("misalign_no_req",  32'(obs_req_cycles), 32'd0);
`endif

        // Illegal funct3 with a stalled consumer.
        do_txn(1'b0, 3'b011, 32'h20, $urandom, 0, 0, 3);
        chk("illegal_err",    obs_rsp_err,  1'b1);
        chk("illegal_data",   obs_rsp_data, 32'h0);
        chk("illegal_no_req", 32'(obs_req_cycles), 32'd0);

        // Memory never acks.
        do_txn(1'b0, 3'b010, 32'h20, $urandom, -1, 0, 0);
        chk("timeout_req_cycles", 32'(obs_req_cycles), 32'd4);
        chk("timeout_err",        obs_rsp_err, 1'b1);

        // Reset while an access is outstanding.
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_acc_mem_req", mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_acc_mem_req_after", mem_req,   1'b0);
        chk("rst_acc_rsp_valid",     rsp_valid, 1'b0);
        chk("rst_acc_req_ready",     req_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("rst_acc_no_rsp", rsp_valid, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            if ($urandom % 2 == 0) begin
                if (f3[1])      addr[1:0] = 2'b00;
                else if (f3[0]) addr[0]   = 1'b0;
            end
            w0 = ($urandom % 12 == 0) ? -1 : int'($urandom % 4);
            w1 = ($urandom % 12 == 0) ? -1 : int'($urandom % 4);
            do_txn(st, f3, addr, $urandom, w0, w1, int'($urandom % 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 255: cycles mem_req may wait for mem_ack before the access is aborted.
REQ-002 The block SHALL have ports `clk` (in, 1): rising-edge clock for all state.
REQ-003 `reset` (in, 1): synchronous, active-high reset.
REQ-004 `req_valid` (in, 1), `req_ready` (out, 1): core request handshake.
REQ-005 `req_store` (in, 1), `req_funct3` (in, 3), `req_addr` (in, 32), `req_wdata` (in, 32): operation, RV32I funct3, byte address, store data.
REQ-006 `rsp_valid` (out, 1), `rsp_ready` (in, 1), `rsp_data` (out, 32), `rsp_err` (out, 1): response handshake, load result, error flag.
REQ-007 `mem_req` (out, 1), `mem_we` (out, 1), `mem_addr` (out, 32, word-aligned), `mem_be` (out, 4), `mem_wdata` (out, 32): data-memory request.
REQ-008 `mem_ack` (in, 1), `mem_rdata` (in, 32): memory completion and read data, valid in the `mem_ack` cycle.

Function
REQ-009 The FSM SHALL have states IDLE, ACC0, ACC1, RESP; `req_ready` is 1 only in IDLE.
REQ-010 On `req_valid` && `req_ready`, all `req_*` fields SHALL be latched, and the FSM moves to ACC0, or to RESP with `rsp_err`=1 for an illegal or misaligned request.
REQ-011 Legal funct3 values:
- loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- stores: 000 SB, 001 SH, 010 SW
- all other codes are illegal, produce `rsp_data`=0, and cause no memory access.
REQ-012 ACC0 drive values:
- `mem_req`=1
- `mem_addr`={addr[31:2],2'b00}
- `mem_be`=low 4 bits of (size mask << addr[1:0])
- `mem_wdata`=wdata << 8*addr[1:0]
- `mem_we`=`req_store`
REQ-013 All `mem_*` outputs SHALL be held stable while `mem_req`=1 and `mem_ack`=0.
REQ-014 On `mem_ack` in ACC0, the FSM goes to ACC1 if the access spans two words, else to RESP.
REQ-015 ACC1 drive values:
- `mem_addr`=ACC0 address+4
- `mem_be`=bits [7:4] of the shifted mask
- `mem_wdata`=wdata >> 8*(4-addr[1:0])
- on `mem_ack`, go to RESP.
REQ-016 Load result SHALL be ({rdata1,rdata0} >> 8*addr[1:0]), truncated to size, then sign-extended (LB/LH) or zero-extended (LBU/LHU); rdata1=0 when no ACC1 occurs.
REQ-017 In RESP, `rsp_valid`=1 with `rsp_data`/`rsp_err` registered and stable until `rsp_ready`; the FSM then returns to IDLE. Stores return `rsp_data`=0.
REQ-018 Same-cycle ack SHALL be supported: with zero-wait memory, an accept in cycle T gives `rsp_valid` in cycle T+2 for a single-word access.
REQ-019 Timeout behaviour:
- A wait counter clears on entry to ACC0/ACC1 and increments each cycle without `mem_ack`.
- When it reaches ACK_TIMEOUT, `mem_req` SHALL drop the next cycle, and the FSM goes to RESP with `rsp_err`=1.
REQ-020 `mem_ack` outside ACC0/ACC1 SHALL be ignored.
REQ-021 `req_valid` outside IDLE SHALL be ignored; there is no queueing.

Reset
REQ-022 Reset values:
- state=IDLE, `req_ready`=1
- `rsp_valid`, `rsp_err`, `rsp_data`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, wait counter all 0
REQ-023 Reset mid-transaction SHALL abandon it with no response, and `mem_req` SHALL be 0 in the cycle after reset is sampled.

Configuration
REQ-024 With `LSU_MISALIGN_SPLIT_EN` defined, misaligned accesses are supported:
- LH/LHU/SH with addr[0]=1
- LW/SW with addr[1:0]!=0
- these execute as one access, or two when crossing a word boundary (per REQ-014/015).
REQ-025 Without `LSU_MISALIGN_SPLIT_EN`, misaligned requests SHALL go to RESP with `rsp_err`=1, and `mem_req` is never asserted for them.

Structure
REQ-026 Package `lsu_pkg` SHALL hold:
- the funct3 enum
- the FSM state enum
- size-mask constants
- the default ACK_TIMEOUT
REQ-027 The combinational load extract/extend of REQ-016 SHALL be sub-module `load_align`, instantiated once.

Verification
REQ-028 LW addr 0x08, `mem_rdata`=0xA5A5A5A5, same-cycle ack -> `mem_be`=1111, `rsp_data`=0xA5A5A5A5, `rsp_valid` at T+2.
REQ-029 Sub-word loads with `mem_rdata`=0x80011234:
- LH addr 0x0A -> `mem_be`=1100, `rsp_data`=0xFFFF8001
- LBU addr 0x0B -> `rsp_data`=0x00000080
REQ-030 SB addr 0x05, wdata 0x000000EE -> `mem_addr`=0x04, `mem_be`=0010, `mem_wdata`=0x0000EE00, `mem_we`=1, `rsp_data`=0.
REQ-031 LW addr 0x0E:
- with macro: access 1 to 0x0C, be 1100, rdata 0xBBAA0000; access 2 to 0x10, be 0011, rdata 0x0000DDCC -> `rsp_data`=0xDDCCBBAA
- without macro: `rsp_err`=1, `mem_req` never high
REQ-032 Load with funct3 011 -> `rsp_err`=1, `rsp_data`=0, no `mem_req`; `rsp_ready` held low 3 cycles -> response held stable.
REQ-033 ACK_TIMEOUT=4, `mem_ack` never asserted -> `mem_req` drops after 4 wait cycles, `rsp_err`=1; reset asserted in ACC0 -> no `rsp_valid`, IDLE next cycle.
